// File: rtl/multi_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : multi_debouncer
//  Brief    : N-channel push-button debouncer. Each channel has its own
//             synchroniser, a four-state debounce FSM with a stability
//             counter, and a long-press timer. It outputs a debounced level
//             and one-cycle press / release / hold strobes.
//  Revision : 1.0  initial release
// ============================================================================
module multi_debouncer #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int HOLD_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] hold
);

    // The debounce counter is one bit wider than strictly needed.
    // This keeps DB_CYCLES == 1 legal.
    localparam int c_DCW = $clog2(DB_CYCLES) + 1;
    // The hold counter has headroom for one extra value, HOLD_CYCLES itself.
    // That value is the saturated "already fired" marker.
    localparam int c_HCW = $clog2(HOLD_CYCLES) + 1;

    localparam logic [c_DCW-1:0] c_DC_LAST = c_DCW'(DB_CYCLES - 1);
    localparam logic [c_HCW-1:0] c_HC_LAST = c_HCW'(HOLD_CYCLES - 1);
    localparam logic [c_HCW-1:0] c_HC_SAT  = c_HCW'(HOLD_CYCLES);
    localparam logic [c_DCW-1:0] c_DC_ONE  = c_DCW'(1);
    localparam logic [c_HCW-1:0] c_HC_ONE  = c_HCW'(1);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch

        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        state_t                 r_state;
        logic [c_DCW-1:0]       r_dc;
        logic [c_HCW-1:0]       r_hc;
        logic                   r_level;
        logic                   r_press;
        logic                   r_release;
        logic                   r_hold;

        // Shift the raw asynchronous button through the synchroniser chain.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], btn[gi]};
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];

        // Debounce FSM, stability counter and long-press timer with registered strobes.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state   <= ST_LOW;
                r_dc      <= '0;
                r_hc      <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_hold    <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_hold    <= 1'b0;

                // The hold timer runs on the debounced level. Bounces that are
                // absorbed in WAIT_LO never drop the level, so they do not disturb it.
                if (r_level) begin
                    if (r_hc == c_HC_LAST) begin
                        r_hold <= 1'b1;
                        r_hc   <= c_HC_SAT;
                    end else if (r_hc != c_HC_SAT) begin
                        r_hc <= r_hc + c_HC_ONE;
                    end
                end

                // The transition assignments below come last in this block.
                // On press and release they override the hold-timer updates above.
                case (r_state)
                    ST_LOW: begin
                        if (w_s) begin
                            r_state <= ST_WAIT_HI;
                            r_dc    <= '0;
                        end
                    end
                    ST_WAIT_HI: begin
                        if (!w_s) begin
                            r_state <= ST_LOW;
                        end else if (r_dc == c_DC_LAST) begin
                            r_state <= ST_HIGH;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                            r_hc    <= '0;
                        end else begin
                            r_dc <= r_dc + c_DC_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (!w_s) begin
                            r_state <= ST_WAIT_LO;
                            r_dc    <= '0;
                        end
                    end
                    ST_WAIT_LO: begin
                        if (w_s) begin
                            r_state <= ST_HIGH;
                        end else if (r_dc == c_DC_LAST) begin
                            // On release, suppress any hold that would have fired this cycle.
                            r_state   <= ST_LOW;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                            r_hold    <= 1'b0;
                            r_hc      <= '0;
                        end else begin
                            r_dc <= r_dc + c_DC_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_LOW;
                    end
                endcase
            end
        end

        assign level[gi]         = r_level;
        assign press[gi]         = r_press;
        assign release_pulse[gi] = r_release;
        assign hold[gi]          = r_hold;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_debouncer
//  Brief    : Directed self-checking bench for multi_debouncer (4 channels,
//             2 sync stages, 16 debounce cycles, 64 hold cycles).
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_debouncer;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] release_pulse;
    logic [3:0] hold;

    int n_checks;
    int n_fail;

    int edge_no;
    int press_cnt [4];
    int press_at  [4];
    int rel_cnt   [4];
    int rel_at    [4];
    int hold_cnt  [4];
    int hold_at   [4];
    int ovl;

    int k, lrise, p1, p2, rl, s0;
    int pc0, pc1, pc2, pc3, hc0, rc0;

    multi_debouncer #(
        .N_CH        (4),
        .SYNC_STAGES (2),
        .DB_CYCLES   (16),
        .HOLD_CYCLES (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .hold          (hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so latencies can be stated in edge numbers.
    always @(posedge clk) edge_no <= edge_no + 1;

    // Record the strobe events, sampled mid-cycle after the edge that produced them.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (press[i])         begin press_cnt[i]++; press_at[i] = edge_no; end
            if (release_pulse[i]) begin rel_cnt[i]++;   rel_at[i]   = edge_no; end
            if (hold[i])          begin hold_cnt[i]++;  hold_at[i]  = edge_no; end
            if ((press[i] && release_pulse[i]) || (press[i] && hold[i])) ovl++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        btn      = 4'b0000;

        // ---- 1: reset state ----
        step(3);
        chk("in_reset_outputs", {level, press, release_pulse, hold}, 16'h0000);
        rst = 1'b0;
        step(2);
        chk("post_reset_level", level, 4'b0000);
        chk("post_reset_press", press, 4'b0000);
        chk("post_reset_rel",   release_pulse, 4'b0000);
        chk("post_reset_hold",  hold, 4'b0000);

        // ---- 2: clean press on channel 0, exact latency ----
        btn[0] = 1'b1;
        k = edge_no + 1;
        step(17);                                   // edge k+16
        step(1);                                    // edge k+17
        chk("press_lat_minus1_level", level, 4'b0000);
        step(1);                                    // edge k+18
        chk("press_lat_level", level, 4'b0001);
        chk("press_lat_press", press, 4'b0001);
        step(1);                                    // edge k+19
        chk("press_one_cycle", press, 4'b0000);
        chk("level_held", level, 4'b0001);
        chk("others_quiet", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

        // ---- 1b: async reset while channel 2 is in WAIT_HI ----
        btn[2] = 1'b1;
        step(8);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", {level, press, release_pulse, hold}, 16'h0000);
        btn = 4'b0000;
        step(2);
        rst = 1'b0;
        pc2 = press_cnt[2];
        step(40);
        chk("no_press_after_rst", press_cnt[2] - pc2, 0);
        chk("level_after_rst", level, 4'b0000);

        // ---- 3: bouncing press on channel 0 ----
        pc0 = press_cnt[0];
        btn[0] = 1'b1; step(10);
        btn[0] = 1'b0; step(4);
        btn[0] = 1'b1; step(6);
        btn[0] = 1'b0; step(1);
        btn[0] = 1'b1;
        lrise = edge_no + 1;
        step(30);
        chk("bounce_press_count", press_cnt[0] - pc0, 1);
        chk("bounce_press_edge", press_at[0], lrise + 18);

        // ---- 4: long hold, then release ----
        p1  = press_at[0];
        hc0 = hold_cnt[0] - ((hold_cnt[0] > 0 && hold_at[0] >= p1) ? 1 : 0);
        hc0 = hold_cnt[0];
        step(p1 + 150 - edge_no);
        chk("hold_count", hold_cnt[0] - hc0, 1);
        chk("hold_edge", hold_at[0], p1 + 64);
        rc0 = rel_cnt[0];
        btn[0] = 1'b0;
        rl = edge_no + 1;
        step(60);
        chk("release_count", rel_cnt[0] - rc0, 1);
        chk("release_edge", rel_at[0], rl + 18);
        chk("no_second_hold", hold_cnt[0] - hc0, 1);
        chk("level_after_release", level, 4'b0000);

        // ---- 6: short dropout while pressed ----
        btn[0] = 1'b1;
        step(25);
        p2  = press_at[0];
        hc0 = hold_cnt[0];
        rc0 = rel_cnt[0];
        btn[0] = 1'b0; step(5);
        btn[0] = 1'b1; step(10);
        chk("dropout_level", level[0], 1'b1);
        step(p2 + 80 - edge_no);
        chk("dropout_no_release", rel_cnt[0] - rc0, 0);
        chk("dropout_hold_count", hold_cnt[0] - hc0, 1);
        chk("dropout_hold_edge", hold_at[0], p2 + 64);
        btn[0] = 1'b0;
        step(30);

        // ---- 5: simultaneous channels, channel 2 bouncing ----
        pc1 = press_cnt[1];
        pc2 = press_cnt[2];
        pc3 = press_cnt[3];
        btn[1] = 1'b1; btn[3] = 1'b1; btn[2] = 1'b1;
        s0 = edge_no + 1;
        step(3);
        btn[2] = 1'b0; step(2);
        btn[2] = 1'b1; step(5);
        btn[2] = 1'b0; step(1);
        btn[2] = 1'b1;
        step(40);
        chk("sim_press1_edge", press_at[1], s0 + 18);
        chk("sim_press3_edge", press_at[3], s0 + 18);
        chk("sim_press2_edge", press_at[2], s0 + 29);
        chk("sim_press_counts", {8'(press_cnt[1] - pc1), 8'(press_cnt[2] - pc2), 8'(press_cnt[3] - pc3)}, 24'h010101);
        chk("sim_level", level, 4'b1110);

        chk("no_coinciding_strobes", ovl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
